mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, 32, address width; DATA_W, 32, data width.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ifetch_req_i  input  1  fetch-stage read request, held until ifetch_ready_o.
REQ-005 ifetch_addr_i  input  ADDR_W  fetch address, stable while ifetch_req_i high.
REQ-006 ifetch_rdata_o  output  DATA_W  fetched word, valid only when ifetch_ready_o high.
REQ-007 ifetch_ready_o  output  1  one-cycle completion pulse for fetch.
REQ-008 data_req_i  input  1  memory-stage request (load or store), held until data_ready_o.
REQ-009 data_we_i  input  1  1 = store, 0 = load.
REQ-010 data_addr_i / data_wdata_i  input  ADDR_W / DATA_W  data address / store data.
REQ-011 data_rdata_o  output  DATA_W  load data, valid only when data_ready_o high.
REQ-012 data_ready_o  output  1  one-cycle completion pulse for data access.
REQ-013 mem_en_o, mem_we_o  output  1 each  single-port memory enable / write enable.
REQ-014 mem_addr_o, mem_wdata_o  output  ADDR_W / DATA_W  memory address / write data.
REQ-015 mem_rdata_i  input  DATA_W  memory read data, valid the cycle after mem_en_o (synchronous read).
REQ-016 stall_f_o, stall_m_o  output  1 each  to hazard unit: requester waiting (req high, ready low).

Function
REQ-017 FSM states: IDLE, RESP_I, RESP_D; one grant per two cycles maximum.
REQ-018 IDLE, no request: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; stay IDLE.
REQ-019 IDLE, grant: mem_* driven combinationally from winner in same cycle, mem_en_o=1; mem_we_o=data_we_i only when data wins, else 0; next state RESP_I or RESP_D.
REQ-020 RESP_x: mem_en_o=0; matching ready pulses 1 for exactly this cycle; rdata output = mem_rdata_i; next state IDLE unconditionally.
REQ-021 Stores also complete with data_ready_o in RESP_D; data_rdata_o value don't-care for stores.
REQ-022 No grant is issued in RESP_I/RESP_D even if requests pending; they wait for IDLE.
REQ-023 Default arbitration (macro absent): fixed priority, data over fetch, when both request in IDLE.
REQ-024 Non-winning requester's ready stays 0; its stall output stays 1 until served.
REQ-025 stall_f_o = ifetch_req_i & ~ifetch_ready_o; stall_m_o = data_req_i & ~data_ready_o; combinational.
REQ-026 Requester dropping req before being granted: no access issued, no ready pulse.
REQ-027 rdata outputs drive 0 whenever corresponding ready is 0.

Reset
REQ-028 reset high: next state IDLE, last-grant register cleared to "fetch", all outputs 0 except stall outputs which follow REQ-025.
REQ-029 reset asserted during RESP_x: no ready pulse that cycle; pending access discarded; requester must re-request.

Configuration
REQ-030 Macro ARB_RR_EN defined: round-robin when both request in IDLE -- winner is the requester not granted last; single requester always granted.
REQ-031 ARB_RR_EN absent: last-grant register not implemented; REQ-023 applies.

Structure
REQ-032 Package mem_arb_pkg holds state enum (IDLE, RESP_I, RESP_D), owner enum (OWN_I, OWN_D), ADDR_W/DATA_W defaults.
REQ-033 One sub-module mem_arb_pick: combinational winner selection (fixed or round-robin); FSM and muxing in mem_arbiter.

Verification
REQ-034 Fetch only, addr 0x10, mem word 0xDEADBEEF -> mem_en_o=1 cycle N, ifetch_ready_o=1 and ifetch_rdata_o=0xDEADBEEF cycle N+1.
REQ-035 Both request same IDLE cycle, load 0x20 and fetch 0x04, macro absent -> data served N/N+1, fetch granted N+2, ready N+3; stall_f_o high N..N+2.
REQ-036 ARB_RR_EN, both held continuously -> grants alternate D,I,D,I on cycles N,N+2,N+4,N+6 after reset (last-grant = fetch).
REQ-037 Store addr 0x0A data 0x0A -> mem_we_o=1, mem_addr_o=0x0A, mem_wdata_o=0x0A cycle N; data_ready_o cycle N+1; a following load of 0x0A returns 0x0A.
REQ-038 reset pulsed in RESP_D -> no data_ready_o, state IDLE next cycle, held request re-granted the cycle after reset drops.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester single-port memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESP_I = 2'd1,
      RESP_D = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Round-robin choice: whoever was not granted last time.
   function automatic owner_e rr_other(input owner_e last_own);
      owner_e w_res;
      if (last_own == OWN_I) begin
         w_res = OWN_D;
      end else begin
         w_res = OWN_I;
      end
      return w_res;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-side signals for mem_arbiter.
// The arbiter uses the slave modport; the environment uses master.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              ifetch_req_i;
   logic [ADDR_W-1:0] ifetch_addr_i;
   logic [DATA_W-1:0] ifetch_rdata_o;
   logic              ifetch_ready_o;

   logic              data_req_i;
   logic              data_we_i;
   logic [ADDR_W-1:0] data_addr_i;
   logic [DATA_W-1:0] data_wdata_i;
   logic [DATA_W-1:0] data_rdata_o;
   logic              data_ready_o;

   logic              mem_en_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   logic              stall_f_o;
   logic              stall_m_o;

   modport slave (
      input  ifetch_req_i, ifetch_addr_i, data_req_i, data_we_i,
             data_addr_i, data_wdata_i, mem_rdata_i,
      output ifetch_rdata_o, ifetch_ready_o, data_rdata_o, data_ready_o,
             mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
             stall_f_o, stall_m_o
   );

   modport master (
      output ifetch_req_i, ifetch_addr_i, data_req_i, data_we_i,
             data_addr_i, data_wdata_i, mem_rdata_i,
      input  ifetch_rdata_o, ifetch_ready_o, data_rdata_o, data_ready_o,
             mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
             stall_f_o, stall_m_o
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// ARB_RR_EN selects round-robin on contention; otherwise data has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_req_i,
   input  logic   i_req_d,
`ifdef ARB_RR_EN
   input  owner_e i_last_own,
`endif
   output logic   o_grant,
   output owner_e o_own
);

   // Winner selection
   always_comb begin
      o_grant = i_req_i | i_req_d;
      o_own   = OWN_I;
      if (i_req_i && i_req_d) begin
`ifdef ARB_RR_EN
         o_own = rr_other(i_last_own);
`else
         o_own = OWN_D;
`endif
      end else if (i_req_d) begin
         o_own = OWN_D;
      end else begin
         o_own = OWN_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port synchronous-read memory: grant in IDLE,
// complete in RESP_x one cycle later. ARB_RR_EN enables round-robin arbitration.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)(
   input logic           clk,
   input logic           reset,
   mem_arbiter_if.slave  bus
);

   state_e            r_state;
   state_e            w_next_state;
   logic              w_grant;
   owner_e            w_own;

   logic              w_mem_en;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_ifetch_ready;
   logic [DATA_W-1:0] w_ifetch_rdata;
   logic              w_data_ready;
   logic [DATA_W-1:0] w_data_rdata;

`ifdef ARB_RR_EN
   owner_e            r_last_own;

   // Remember who was granted last, used to alternate on contention
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_own <= OWN_I;
      end else if ((r_state == IDLE) && w_grant) begin
         r_last_own <= w_own;
      end else begin
         r_last_own <= r_last_own;
      end
   end
`endif

   mem_arb_pick u_pick (
      .i_req_i    (bus.ifetch_req_i),
      .i_req_d    (bus.data_req_i),
`ifdef ARB_RR_EN
      .i_last_own (r_last_own),
`endif
      .o_grant    (w_grant),
      .o_own      (w_own)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = IDLE;
      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_next_state = (w_own == OWN_D) ? RESP_D : RESP_I;
            end else begin
               w_next_state = IDLE;
            end
         end
         RESP_I:  w_next_state = IDLE;
         RESP_D:  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Output logic; everything is forced quiet while reset is high so an
   // in-flight response is dropped rather than delivered.
   always_comb begin
      w_mem_en       = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_addr     = {ADDR_W{1'b0}};
      w_mem_wdata    = {DATA_W{1'b0}};
      w_ifetch_ready = 1'b0;
      w_ifetch_rdata = {DATA_W{1'b0}};
      w_data_ready   = 1'b0;
      w_data_rdata   = {DATA_W{1'b0}};
      if (!reset) begin
         case (r_state)
            IDLE: begin
               if (w_grant && (w_own == OWN_D)) begin
                  w_mem_en    = 1'b1;
                  w_mem_we    = bus.data_we_i;
                  w_mem_addr  = bus.data_addr_i;
                  w_mem_wdata = bus.data_we_i ? bus.data_wdata_i : {DATA_W{1'b0}};
               end else if (w_grant) begin
                  w_mem_en    = 1'b1;
                  w_mem_addr  = bus.ifetch_addr_i;
               end else begin
                  w_mem_en    = 1'b0;
               end
            end
            RESP_I: begin
               w_ifetch_ready = 1'b1;
               w_ifetch_rdata = bus.mem_rdata_i;
            end
            RESP_D: begin
               w_data_ready = 1'b1;
               w_data_rdata = bus.mem_rdata_i;
            end
            default: begin
               w_mem_en = 1'b0;
            end
         endcase
      end else begin
         w_mem_en = 1'b0;
      end
   end

   assign bus.mem_en_o       = w_mem_en;
   assign bus.mem_we_o       = w_mem_we;
   assign bus.mem_addr_o     = w_mem_addr;
   assign bus.mem_wdata_o    = w_mem_wdata;
   assign bus.ifetch_ready_o = w_ifetch_ready;
   assign bus.ifetch_rdata_o = w_ifetch_rdata;
   assign bus.data_ready_o   = w_data_ready;
   assign bus.data_rdata_o   = w_data_rdata;
   assign bus.stall_f_o      = bus.ifetch_req_i & ~w_ifetch_ready;
   assign bus.stall_m_o      = bus.data_req_i & ~w_data_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];
   bit   [255:0] written;

   function automatic logic [31:0] preset(input logic [7:0] a);
      case (a)
         8'h10:   return 32'hDEADBEEF;
         8'h20:   return 32'h12345678;
         8'h04:   return 32'hCAFEF00D;
         default: return 32'h0000_0000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.mem_en_o) begin
         if (bus.mem_we_o) begin
            mem[bus.mem_addr_o[7:0]]     <= bus.mem_wdata_o;
            written[bus.mem_addr_o[7:0]] <= 1'b1;
         end else begin
            bus.mem_rdata_i <= written[bus.mem_addr_o[7:0]] ? mem[bus.mem_addr_o[7:0]]
                                                             : preset(bus.mem_addr_o[7:0]);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h10;
      next_cycle(); next_cycle(); settle();
      n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got %0h want 0", bus.mem_en_o); end
      n_checks++; if (bus.ifetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready got %0h want 0", bus.ifetch_ready_o); end
      n_checks++; if (bus.stall_f_o !== 1'b1) begin n_fail++; $display("FAIL rst_stall_f got %0h want 1", bus.stall_f_o); end
      next_cycle(); bus.ifetch_req_i = 1'b0; settle();
      n_checks++; if (bus.stall_f_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall_f_low got %0h want 0", bus.stall_f_o); end
      n_checks++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got %0h want 0", bus.mem_addr_o); end
      next_cycle(); reset = 1'b0; settle();
      n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL idle_mem_en got %0h want 0", bus.mem_en_o); end
   endtask

   task automatic test_fetch();
      next_cycle(); bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h10; settle();
      n_checks++; if (bus.mem_en_o !== 1'b1) begin n_fail++; $display("FAIL fetch_en got %0h want 1", bus.mem_en_o); end
      n_checks++; if (bus.mem_addr_o !== 32'h10) begin n_fail++; $display("FAIL fetch_addr got %0h want 10", bus.mem_addr_o); end
      n_checks++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL fetch_we got %0h want 0", bus.mem_we_o); end
      n_checks++; if (bus.ifetch_rdata_o !== 32'h0) begin n_fail++; $display("FAIL fetch_rdata_idle got %0h want 0", bus.ifetch_rdata_o); end
      next_cycle(); settle();
      n_checks++; if (bus.ifetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL fetch_ready got %0h want 1", bus.ifetch_ready_o); end
      n_checks++; if (bus.ifetch_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata got %0h want deadbeef", bus.ifetch_rdata_o); end
      n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL fetch_resp_en got %0h want 0", bus.mem_en_o); end
      n_checks++; if (bus.stall_f_o !== 1'b0) begin n_fail++; $display("FAIL fetch_stall got %0h want 0", bus.stall_f_o); end
      next_cycle(); bus.ifetch_req_i = 1'b0; settle();
      n_checks++; if (bus.ifetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL fetch_one_pulse got %0h want 0", bus.ifetch_ready_o); end
   endtask

   task automatic test_priority();
      next_cycle();
      bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h20;
      bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h04; settle();
      n_checks++; if (bus.mem_addr_o !== 32'h20) begin n_fail++; $display("FAIL prio_addr got %0h want 20", bus.mem_addr_o); end
      n_checks++; if (bus.stall_f_o !== 1'b1) begin n_fail++; $display("FAIL prio_stall_f_n got %0h want 1", bus.stall_f_o); end
      next_cycle(); settle();
      n_checks++; if (bus.data_ready_o !== 1'b1) begin n_fail++; $display("FAIL prio_d_ready got %0h want 1", bus.data_ready_o); end
      n_checks++; if (bus.data_rdata_o !== 32'h12345678) begin n_fail++; $display("FAIL prio_d_rdata got %0h want 12345678", bus.data_rdata_o); end
      n_checks++; if (bus.ifetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL prio_i_ready_n1 got %0h want 0", bus.ifetch_ready_o); end
      n_checks++; if (bus.stall_f_o !== 1'b1) begin n_fail++; $display("FAIL prio_stall_f_n1 got %0h want 1", bus.stall_f_o); end
      n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL prio_no_grant_resp got %0h want 0", bus.mem_en_o); end
      next_cycle(); bus.data_req_i = 1'b0; settle();
      n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h04) begin n_fail++; $display("FAIL prio_i_grant got en=%0h addr=%0h want en=1 addr=4", bus.mem_en_o, bus.mem_addr_o); end
      n_checks++; if (bus.stall_f_o !== 1'b1) begin n_fail++; $display("FAIL prio_stall_f_n2 got %0h want 1", bus.stall_f_o); end
      next_cycle(); settle();
      n_checks++; if (bus.ifetch_ready_o !== 1'b1 || bus.ifetch_rdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL prio_i_resp got rdy=%0h data=%0h want rdy=1 data=cafef00d", bus.ifetch_ready_o, bus.ifetch_rdata_o); end
      n_checks++; if (bus.data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL prio_d_rdata_zero got %0h want 0", bus.data_rdata_o); end
      next_cycle(); bus.ifetch_req_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_addr_i = 32'h0A; bus.data_wdata_i = 32'h0A; settle();
      n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b1) begin n_fail++; $display("FAIL st_en_we got en=%0h we=%0h want 1 1", bus.mem_en_o, bus.mem_we_o); end
      n_checks++; if (bus.mem_addr_o !== 32'h0A || bus.mem_wdata_o !== 32'h0A) begin n_fail++; $display("FAIL st_addr_wdata got %0h %0h want a a", bus.mem_addr_o, bus.mem_wdata_o); end
      next_cycle(); settle();
      n_checks++; if (bus.data_ready_o !== 1'b1) begin n_fail++; $display("FAIL st_ready got %0h want 1", bus.data_ready_o); end
      next_cycle(); bus.data_we_i = 1'b0; bus.data_wdata_i = 32'h0; settle();
      n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h0A) begin n_fail++; $display("FAIL ld_grant got en=%0h we=%0h addr=%0h want 1 0 a", bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o); end
      next_cycle(); settle();
      n_checks++; if (bus.data_ready_o !== 1'b1 || bus.data_rdata_o !== 32'h0A) begin n_fail++; $display("FAIL ld_resp got rdy=%0h data=%0h want 1 a", bus.data_ready_o, bus.data_rdata_o); end
      next_cycle(); bus.data_req_i = 1'b0;
   endtask

   task automatic test_drop();
      bus.data_req_i = 1'b1; bus.data_addr_i = 32'h20;
      next_cycle(); bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h10; settle();
      n_checks++; if (bus.data_ready_o !== 1'b1 || bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL drop_resp got rdy=%0h en=%0h want 1 0", bus.data_ready_o, bus.mem_en_o); end
      next_cycle(); bus.ifetch_req_i = 1'b0; bus.data_req_i = 1'b0; settle();
      n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL drop_no_access got %0h want 0", bus.mem_en_o); end
      next_cycle(); settle();
      n_checks++; if (bus.ifetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL drop_no_ready got %0h want 0", bus.ifetch_ready_o); end
   endtask

   task automatic test_reset_resp();
      next_cycle(); bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h20;
      next_cycle(); reset = 1'b1; settle();
      n_checks++; if (bus.data_ready_o !== 1'b0 || bus.data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rr_no_ready got rdy=%0h data=%0h want 0 0", bus.data_ready_o, bus.data_rdata_o); end
      n_checks++; if (bus.stall_m_o !== 1'b1) begin n_fail++; $display("FAIL rr_stall_m got %0h want 1", bus.stall_m_o); end
      next_cycle(); reset = 1'b0; settle();
      n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h20) begin n_fail++; $display("FAIL rr_regrant got en=%0h addr=%0h want 1 20", bus.mem_en_o, bus.mem_addr_o); end
      next_cycle(); settle();
      n_checks++; if (bus.data_ready_o !== 1'b1 || bus.data_rdata_o !== 32'h12345678) begin n_fail++; $display("FAIL rr_resp got rdy=%0h data=%0h want 1 12345678", bus.data_ready_o, bus.data_rdata_o); end
      next_cycle(); bus.data_req_i = 1'b0;
   endtask

`ifdef ARB_RR_EN
   task automatic test_round_robin();
      logic [31:0] exp_addr [4];
      exp_addr[0] = 32'h20; exp_addr[1] = 32'h04; exp_addr[2] = 32'h20; exp_addr[3] = 32'h04;
      reset = 1'b1;
      next_cycle(); reset = 1'b0;
      bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h20;
      bus.ifetch_req_i = 1'b1; bus.ifetch_addr_i = 32'h04;
      for (int k = 0; k < 4; k++) begin
         settle();
         n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== exp_addr[k]) begin n_fail++; $display("FAIL rr_grant%0d got en=%0h addr=%0h want 1 %0h", k, bus.mem_en_o, bus.mem_addr_o, exp_addr[k]); end
         next_cycle(); next_cycle();
      end
      bus.data_req_i = 1'b0; bus.ifetch_req_i = 1'b0;
   endtask
`endif

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b1;
      bus.ifetch_req_i = 1'b0; bus.ifetch_addr_i = 32'h0;
      bus.data_req_i = 1'b0; bus.data_we_i = 1'b0;
      bus.data_addr_i = 32'h0; bus.data_wdata_i = 32'h0;
      test_reset();
      test_fetch();
      test_priority();
      test_back_to_back();
      test_drop();
      test_reset_resp();
`ifdef ARB_RR_EN
      test_round_robin();
`endif
      next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
